// File: rtl/clear_sequencer.sv
// Command front-end for clear_unit: queues clear rectangles, clamps them to the
// framebuffer, drops empty ones and dispatches the rest one at a time.
module clear_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_WIDTH   = 640,
    parameter int unsigned FB_HEIGHT  = 480
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_color,
    input  logic [31:0] cmd_xmin,
    input  logic [31:0] cmd_ymin,
    input  logic [31:0] cmd_xmax,
    input  logic [31:0] cmd_ymax,

    output logic        cu_start,
    input  logic        cu_done,
    output logic [31:0] cu_color,
    output logic [31:0] cu_xmin,
    output logic [31:0] cu_ymin,
    output logic [31:0] cu_xmax,
    output logic [31:0] cu_ymax,

    output logic        busy,
    output logic [15:0] cmds_done,
    output logic [15:0] cmds_skipped
);

    localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [31:0] X_LIMIT    = 32'(FB_WIDTH);
    localparam logic [31:0] Y_LIMIT    = 32'(FB_HEIGHT);

    typedef struct packed {
        logic [31:0] color;
        logic [31:0] xmin;
        logic [31:0] ymin;
        logic [31:0] xmax;
        logic [31:0] ymax;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT
    } state_t;

    state_t        state_q;
    rect_t         cmd_q;

    rect_t         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    rect_t         cmd_in;
    rect_t         head;

    logic [31:0]   clamp_xmax;
    logic [31:0]   clamp_ymax;
    logic          degenerate;

    // ------------------------------------------------------------------
    // Command FIFO. No bypass when full: a pop frees a slot for the next edge.
    // ------------------------------------------------------------------
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign cmd_in     = {cmd_color, cmd_xmin, cmd_ymin, cmd_xmax, cmd_ymax};
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Clamp the far edges to the framebuffer; the near edges pass through.
    // ------------------------------------------------------------------
    always_comb begin
        clamp_xmax = (cmd_q.xmax < X_LIMIT) ? cmd_q.xmax : X_LIMIT;
        clamp_ymax = (cmd_q.ymax < Y_LIMIT) ? cmd_q.ymax : Y_LIMIT;
        degenerate = (cmd_q.xmin >= clamp_xmax) || (cmd_q.ymin >= clamp_ymax);
    end

    // ------------------------------------------------------------------
    // Dispatch sequencer with registered clear_unit interface and counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            cu_start     <= 1'b0;
            cu_color     <= '0;
            cu_xmin      <= '0;
            cu_ymin      <= '0;
            cu_xmax      <= '0;
            cu_ymax      <= '0;
            cmds_done    <= '0;
            cmds_skipped <= '0;
        end else begin
            cu_start <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q   <= head;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (degenerate) begin
                        cmds_skipped <= cmds_skipped + 16'd1;
                        state_q      <= ST_IDLE;
                    end else begin
                        cu_color <= cmd_q.color;
                        cu_xmin  <= cmd_q.xmin;
                        cu_ymin  <= cmd_q.ymin;
                        cu_xmax  <= clamp_xmax;
                        cu_ymax  <= clamp_ymax;
                        cu_start <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Done pulses outside this state are deliberately dropped.
                    if (cu_done) begin
                        cmds_done <= cmds_done + 16'd1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_clear_sequencer.sv
// Bench for clear_sequencer: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_clear_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FBW   = 640;
    localparam int unsigned FBH   = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_color, cmd_xmin, cmd_ymin, cmd_xmax, cmd_ymax;
    logic        cu_start;
    logic        cu_done;
    logic [31:0] cu_color, cu_xmin, cu_ymin, cu_xmax, cu_ymax;
    logic        busy;
    logic [15:0] cmds_done;
    logic [15:0] cmds_skipped;

    always #5 clk = ~clk;

    clear_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .FB_WIDTH  (FBW),
        .FB_HEIGHT (FBH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_color   (cmd_color),
        .cmd_xmin    (cmd_xmin),
        .cmd_ymin    (cmd_ymin),
        .cmd_xmax    (cmd_xmax),
        .cmd_ymax    (cmd_ymax),
        .cu_start    (cu_start),
        .cu_done     (cu_done),
        .cu_color    (cu_color),
        .cu_xmin     (cu_xmin),
        .cu_ymin     (cu_ymin),
        .cu_xmax     (cu_xmax),
        .cu_ymax     (cu_ymax),
        .busy        (busy),
        .cmds_done   (cmds_done),
        .cmds_skipped(cmds_skipped)
    );

    typedef struct {
        logic [31:0] color, xmin, ymin, xmax, ymax;
    } rect_t;

    typedef struct {
        rect_t cmd;
        bit    dispatch;
        rect_t exp;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    exp_done = 0;
    int    exp_skip = 0;
    rect_t exp_last;
    vec_t  vecs[10];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rect_t mk(input logic [31:0] c, input logic [31:0] x0,
                                 input logic [31:0] y0, input logic [31:0] x1,
                                 input logic [31:0] y1);
        rect_t r;
        r.color = c; r.xmin = x0; r.ymin = y0; r.xmax = x1; r.ymax = y1;
        return r;
    endfunction

    // Reference rules: far edges limited to the framebuffer; empty area is dropped.
    function automatic rect_t clamp_ref(input rect_t c);
        rect_t r = c;
        if (r.xmax > FBW) r.xmax = FBW;
        if (r.ymax > FBH) r.ymax = FBH;
        return r;
    endfunction

    function automatic bit empty_ref(input rect_t c);
        rect_t r = clamp_ref(c);
        return (r.xmin >= r.xmax) || (r.ymin >= r.ymax);
    endfunction

    function automatic rect_t rand_rect();
        rect_t r;
        r.color = $urandom;
        r.xmin  = $urandom_range(0, 700);
        r.xmax  = $urandom_range(0, 1000);
        r.ymin  = $urandom_range(0, 520);
        r.ymax  = $urandom_range(0, 800);
        if ($urandom_range(0, 7) == 0) r.xmax = $urandom;
        if ($urandom_range(0, 7) == 0) r.ymax = $urandom;
        if ($urandom_range(0, 15) == 0) r.xmin = $urandom;
        return r;
    endfunction

    task automatic drive_cmd(input rect_t c);
        cmd_color = c.color; cmd_xmin = c.xmin; cmd_ymin = c.ymin;
        cmd_xmax = c.xmax; cmd_ymax = c.ymax;
    endtask

    task automatic check_rect(input string p, input rect_t e);
        check32({p, "_color"}, cu_color, e.color);
        check32({p, "_xmin"}, cu_xmin, e.xmin);
        check32({p, "_ymin"}, cu_ymin, e.ymin);
        check32({p, "_xmax"}, cu_xmax, e.xmax);
        check32({p, "_ymax"}, cu_ymax, e.ymax);
    endtask

    task automatic check_reset(input string p);
        check32({p, "_cu_start"}, 32'(cu_start), 0);
        check_rect(p, mk(0, 0, 0, 0, 0));
        check32({p, "_cmds_done"}, 32'(cmds_done), 0);
        check32({p, "_cmds_skipped"}, 32'(cmds_skipped), 0);
        check32({p, "_busy"}, 32'(busy), 0);
        check32({p, "_cmd_ready"}, 32'(cmd_ready), 1);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_cmd(input rect_t c);
        bit acc = 1'b0;
        drive_cmd(c);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check32("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_start(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            seen = cu_start;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p = $sformatf("vec%0d", idx);
        drive_cmd(v.cmd);
        cmd_valid = 1'b1;
        @(negedge clk);
        check32({p, "_ready"}, 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check32({p, "_start_e0"}, 32'(cu_start), 0);
        check32({p, "_busy"}, 32'(busy), 1);
        @(negedge clk);
        check32({p, "_start_e1"}, 32'(cu_start), 0);
        @(negedge clk);
        check32({p, "_start_e2"}, 32'(cu_start), 32'(v.dispatch));
        if (v.dispatch) begin
            exp_last = v.exp;
            check_rect(p, v.exp);
            @(negedge clk);
            check32({p, "_start_one_cycle"}, 32'(cu_start), 0);
            repeat (6) @(posedge clk);
            #1 cu_done = 1'b1;
            @(posedge clk);
            #1 cu_done = 1'b0;
            exp_done++;
            @(negedge clk);
            check32({p, "_cmds_done"}, 32'(cmds_done), 32'(exp_done));
            check32({p, "_busy_after"}, 32'(busy), 0);
        end else begin
            exp_skip++;
            check32({p, "_busy_after"}, 32'(busy), 0);
            check_rect({p, "_held"}, exp_last);
        end
        check32({p, "_cmds_skipped"}, 32'(cmds_skipped), 32'(exp_skip));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit    seen;
        rect_t fc[6];
        rect_t pend[$];
        rect_t cur;
        rect_t e;
        bit    outstanding;
        bit    will_accept;
        int    delay;
        int    dones;

        vecs[0] = '{mk(32'hFF00FF00, 0, 0, 4, 2), 1'b1, mk(32'hFF00FF00, 0, 0, 4, 2)};
        vecs[1] = '{mk(32'h12345678, 600, 470, 1000, 9999), 1'b1,
                    mk(32'h12345678, 600, 470, 640, 480)};
        vecs[2] = '{mk(32'h0000000A, 5, 0, 5, 10), 1'b0, mk(0, 0, 0, 0, 0)};
        vecs[3] = '{mk(32'h0000000B, 700, 0, 800, 10), 1'b0, mk(0, 0, 0, 0, 0)};
        vecs[4] = '{mk(32'hC0C0C0C0, 0, 0, 640, 480), 1'b1, mk(32'hC0C0C0C0, 0, 0, 640, 480)};
        vecs[5] = '{mk(32'hDDDDDDDD, 639, 479, 32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1,
                    mk(32'hDDDDDDDD, 639, 479, 640, 480)};
        vecs[6] = '{mk(32'h0000000E, 10, 20, 10, 21), 1'b0, mk(0, 0, 0, 0, 0)};
        vecs[7] = '{mk(32'h0000000F, 0, 480, 5, 1000), 1'b0, mk(0, 0, 0, 0, 0)};
        vecs[8] = '{mk(32'h00000009, 3, 4, 1, 9), 1'b0, mk(0, 0, 0, 0, 0)};
        vecs[9] = '{mk(32'h00000007, 1, 1, 2, 2), 1'b1, mk(32'h00000007, 1, 1, 2, 2)};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cu_done = 1'b0;
        drive_cmd(mk(0, 0, 0, 0, 0));
        exp_last = mk(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Stray done pulses while idle and while a command is being checked.
        cu_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 cu_done = 1'b0;
        @(negedge clk);
        check32("spur_idle_done", 32'(cmds_done), 32'(exp_done));
        check32("spur_idle_skip", 32'(cmds_skipped), 32'(exp_skip));
        check32("spur_idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1 drive_cmd(mk(32'hA5A5A5A5, 0, 0, 8, 8));
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cu_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 cu_done = 1'b0;
        @(negedge clk);
        check32("spur_check_start", 32'(cu_start), 1);
        check32("spur_check_done", 32'(cmds_done), 32'(exp_done));
        @(posedge clk);
        #1 cu_done = 1'b1;
        @(posedge clk);
        #1 cu_done = 1'b0;
        exp_done++;
        @(negedge clk);
        check32("spur_real_done", 32'(cmds_done), 32'(exp_done));
        @(posedge clk);
        #1;

        // Fill the FIFO behind an outstanding command.
        for (int k = 0; k < 6; k++) fc[k] = mk(32'h100 + k, k, 0, k + 10, 5);
        push_cmd(fc[0]);
        wait_start(10, seen);
        check32("fill_first_start", 32'(seen), 1);
        check32("fill_first_xmin", cu_xmin, 0);
        @(posedge clk);
        #1;
        for (int k = 1; k < 5; k++) push_cmd(fc[k]);
        drive_cmd(fc[5]);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("fill_ready_full", 32'(cmd_ready), 0);
            check32("fill_busy", 32'(busy), 1);
        end
        @(posedge clk);
        #1 cu_done = 1'b1;
        @(posedge clk);
        #1 cu_done = 1'b0;
        exp_done++;
        @(negedge clk);
        check32("fill_ready_after_done", 32'(cmd_ready), 0);
        @(negedge clk);
        check32("fill_ready_after_pop", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check32("fill_ready_refull", 32'(cmd_ready), 0);
        check32("fill_start_1", 32'(cu_start), 1);
        check32("fill_xmin_1", cu_xmin, 1);
        for (int k = 2; k < 6; k++) begin
            @(posedge clk);
            #1 cu_done = 1'b1;
            @(posedge clk);
            #1 cu_done = 1'b0;
            exp_done++;
            @(negedge clk);
            check32($sformatf("fill_gap_a_%0d", k), 32'(cu_start), 0);
            @(negedge clk);
            check32($sformatf("fill_gap_b_%0d", k), 32'(cu_start), 0);
            @(negedge clk);
            check32($sformatf("fill_start_%0d", k), 32'(cu_start), 1);
            check32($sformatf("fill_xmin_%0d", k), cu_xmin, k);
            check32($sformatf("fill_xmax_%0d", k), cu_xmax, k + 10);
        end
        @(posedge clk);
        #1 cu_done = 1'b1;
        @(posedge clk);
        #1 cu_done = 1'b0;
        exp_done++;
        @(negedge clk);
        check32("fill_cmds_done", 32'(cmds_done), 32'(exp_done));
        check32("fill_busy_end", 32'(busy), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset while waiting on clear_unit with three queued.
        push_cmd(mk(32'hBEEF0000, 0, 0, 20, 20));
        wait_start(10, seen);
        check32("rst_pre_start", 32'(seen), 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) push_cmd(mk(32'h200 + k, 1, 1, 30, 30));
        #2 rst = 1'b1;
        #1 check_reset("midrst");
        exp_done = 0;
        exp_skip = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("midrst_no_start", 32'(cu_start), 0);
            check32("midrst_busy", 32'(busy), 0);
        end
        @(posedge clk);
        #1;

        // Random traffic with a clear_unit model and stray done pulses.
        outstanding = 1'b0;
        delay = 0;
        dones = 0;
        cur = mk(0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cu_start) begin
                check32("rnd_start_while_busy", 32'(outstanding), 0);
                while (pend.size() > 0 && empty_ref(pend[0])) begin
                    void'(pend.pop_front());
                    exp_skip++;
                end
                check32("rnd_start_expected", 32'(pend.size() > 0), 1);
                if (pend.size() > 0) begin
                    e = clamp_ref(pend.pop_front());
                    check_rect("rnd_dispatch", e);
                end
                check32("rnd_skipped", 32'(cmds_skipped), 32'(16'(exp_skip)));
                check32("rnd_done", 32'(cmds_done), 32'(16'(dones)));
                outstanding = 1'b1;
                delay = $urandom_range(1, 6);
            end
            will_accept = cmd_valid && cmd_ready;
            if (will_accept) pend.push_back(cur);
            @(posedge clk);
            #1;
            if (will_accept) cmd_valid = 1'b0;
            cu_done = 1'b0;
            if (outstanding) begin
                delay--;
                if (delay == 0) begin
                    cu_done = 1'b1;
                    outstanding = 1'b0;
                    dones++;
                end
            end else if (!cu_start && $urandom_range(0, 15) == 0) begin
                cu_done = 1'b1;
            end
            if (!cmd_valid && cyc < 3000 && $urandom_range(0, 2) == 0) begin
                cur = rand_rect();
                drive_cmd(cur);
                cmd_valid = 1'b1;
            end
        end
        cu_done = 1'b0;
        while (pend.size() > 0 && empty_ref(pend[0])) begin
            void'(pend.pop_front());
            exp_skip++;
        end
        @(negedge clk);
        check32("rnd_end_pending", 32'(pend.size()), 0);
        check32("rnd_end_outstanding", 32'(outstanding), 0);
        check32("rnd_end_skipped", 32'(cmds_skipped), 32'(16'(exp_skip)));
        check32("rnd_end_done", 32'(cmds_done), 32'(16'(dones)));
        check32("rnd_end_busy", 32'(busy), 0);
        check32("rnd_end_ready", 32'(cmd_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
